// File: rtl/tehlike_puan_tablosu_pkg.sv
// ---------------------------------------------------------------------------
// tehlike_paket
// Shared definitions for the hazard / forwarding scoreboard slice.
//   VARSAYILAN_ADRES_BIT : default register address width
//   SEC_RF, SEC_ASAMA0   : forwarding select encoding (0 = register file,
//                          SEC_ASAMA0 + k = forward from stage k)
//   tablo_indeksi()      : scoreboard index {fp, adres}
// ---------------------------------------------------------------------------
package tehlike_paket;

    localparam int VARSAYILAN_ADRES_BIT = 5;

    localparam int SEC_RF     = 0;
    localparam int SEC_ASAMA0 = 1;

    // Scoreboard index is the FP flag placed directly above the address bits.
    // Returned 32 bits wide so callers can cast it to their own index width.
    function automatic logic [31:0] tablo_indeksi(input logic        fp,
                                                  input logic [31:0] adres,
                                                  input int          adres_bit);
        return (32'(fp) << adres_bit) | adres;
    endfunction

endpackage

// File: rtl/tehlike_puan_tablosu_girdisi.sv
// ---------------------------------------------------------------------------
// puan_tablosu_girdisi
// One scoreboard entry: a busy bit plus a latency countdown.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   yukle_i       : an instruction targeting this entry issues this cycle
//   gecikme_i     : countdown value to load on issue
//   mesgul_o      : entry is busy (result not yet on stage 0)
// ---------------------------------------------------------------------------
module puan_tablosu_girdisi #(
    parameter int GECIKME_BIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   yukle_i,
    input  logic [GECIKME_BIT-1:0] gecikme_i,
    output logic                   mesgul_o
);

    logic                   mesgul_q, mesgul_d;
    logic [GECIKME_BIT-1:0] sayac_q,  sayac_d;

    // Countdown while busy; the busy bit drops on the edge where the
    // counter goes 1->0. A new issue on the same edge overrides completion.
    always_comb begin
        mesgul_d = mesgul_q;
        sayac_d  = sayac_q;
        if (mesgul_q) begin
            sayac_d = sayac_q - GECIKME_BIT'(1);
            if (sayac_q == GECIKME_BIT'(1)) begin
                mesgul_d = 1'b0;
            end
        end
        if (yukle_i) begin
            mesgul_d = 1'b1;
            sayac_d  = gecikme_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mesgul_q <= 1'b0;
            sayac_q  <= '0;
        end else begin
            mesgul_q <= mesgul_d;
            sayac_q  <= sayac_d;
        end
    end

    assign mesgul_o = mesgul_q;

endmodule

// File: rtl/tehlike_puan_tablosu.sv
// ---------------------------------------------------------------------------
// tehlike_puan_tablosu
// Hazard unit beside decode: forwarding selects for KAYNAK_SAYISI sources
// across ASAMA_SAYISI stages, load-use / multi-cycle / WAW stall, and flush.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   kaynak_adres_i/fp_i/kullan_i : decode sources (packed, source 0 in LSBs)
//   asama_rd_yaz_i/adres_i/fp_i/hazir_i : per forwarding stage (0 = yurut)
//   coz_gecerli_i, coz_rd_yaz_i, coz_rd_adres_i, coz_rd_fp_i, coz_gecikme_i
//                             : decoded instruction destination and latency
//   dallanma_gerceklesti_i    : branch taken / flush
//   yonlendirme_sec_o         : per-source select (0 = RF, k+1 = stage k)
//   durdur_o                  : stall fetch/decode
//   getir_atla_o              : flush fetch
// Optional macro TEHLIKE_ISTATISTIK_EN adds durdurma_sayaci_o and
// yonlendirme_sayaci_o (32-bit wrapping statistics counters).
// ---------------------------------------------------------------------------
module tehlike_puan_tablosu
    import tehlike_paket::*;
#(
    parameter  int KAYNAK_SAYISI = 3,
    parameter  int ASAMA_SAYISI  = 2,
    parameter  int ADRES_BIT     = VARSAYILAN_ADRES_BIT,
    parameter  int GECIKME_BIT   = 4,
    localparam int SEC_BIT       = $clog2(ASAMA_SAYISI + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [KAYNAK_SAYISI*ADRES_BIT-1:0] kaynak_adres_i,
    input  logic [KAYNAK_SAYISI-1:0]           kaynak_fp_i,
    input  logic [KAYNAK_SAYISI-1:0]           kaynak_kullan_i,
    input  logic [ASAMA_SAYISI-1:0]            asama_rd_yaz_i,
    input  logic [ASAMA_SAYISI*ADRES_BIT-1:0]  asama_rd_adres_i,
    input  logic [ASAMA_SAYISI-1:0]            asama_rd_fp_i,
    input  logic [ASAMA_SAYISI-1:0]            asama_rd_hazir_i,
    input  logic                               coz_gecerli_i,
    input  logic                               coz_rd_yaz_i,
    input  logic [ADRES_BIT-1:0]               coz_rd_adres_i,
    input  logic                               coz_rd_fp_i,
    input  logic [GECIKME_BIT-1:0]             coz_gecikme_i,
    input  logic                               dallanma_gerceklesti_i,
    output logic [KAYNAK_SAYISI*SEC_BIT-1:0]   yonlendirme_sec_o,
    output logic                               durdur_o,
    output logic                               getir_atla_o
`ifdef TEHLIKE_ISTATISTIK_EN
    ,
    output logic [31:0]                        durdurma_sayaci_o,
    output logic [31:0]                        yonlendirme_sayaci_o
`endif
);

    localparam int INDEKS_BIT   = ADRES_BIT + 1;
    localparam int GIRDI_SAYISI = 1 << INDEKS_BIT;

    logic [GIRDI_SAYISI-1:0] mesgul;
    logic [GIRDI_SAYISI-1:0] yukle;
    logic [INDEKS_BIT-1:0]   coz_indeks;
    logic                    coz_rd_gercek;
    logic                    ver;
    logic                    yukleme_riski;
    logic                    mesgul_riski;
    logic                    waw_riski;

    // Scoreboard entries, one per {fp, adres}.
    for (genvar i = 0; i < GIRDI_SAYISI; i++) begin : g_girdi
        puan_tablosu_girdisi #(
            .GECIKME_BIT (GECIKME_BIT)
        ) u_girdi (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .yukle_i   (yukle[i]),
            .gecikme_i (coz_gecikme_i),
            .mesgul_o  (mesgul[i])
        );
    end

    // Forwarding priority scan: the nearest matching stage wins. Integer x0
    // is hardwired zero, so it neither forwards nor is tracked as busy.
    always_comb begin
        logic [ADRES_BIT-1:0]  adres_s;
        logic                  fp_s;
        logic                  gercek_s;
        logic                  bulundu;
        logic [INDEKS_BIT-1:0] indeks_s;
        yonlendirme_sec_o = '0;
        yukleme_riski     = 1'b0;
        mesgul_riski      = 1'b0;
        adres_s           = '0;
        fp_s              = 1'b0;
        gercek_s          = 1'b0;
        bulundu           = 1'b0;
        indeks_s          = '0;
        for (int s = 0; s < KAYNAK_SAYISI; s++) begin
            adres_s  = kaynak_adres_i[s*ADRES_BIT +: ADRES_BIT];
            fp_s     = kaynak_fp_i[s];
            gercek_s = fp_s || (adres_s != '0);
            indeks_s = INDEKS_BIT'(tablo_indeksi(fp_s, 32'(adres_s), ADRES_BIT));
            bulundu  = 1'b0;
            if (kaynak_kullan_i[s] && gercek_s) begin
                for (int k = 0; k < ASAMA_SAYISI; k++) begin
                    if (!bulundu && asama_rd_yaz_i[k] &&
                        (asama_rd_adres_i[k*ADRES_BIT +: ADRES_BIT] == adres_s) &&
                        (asama_rd_fp_i[k] == fp_s)) begin
                        bulundu = 1'b1;
                        yonlendirme_sec_o[s*SEC_BIT +: SEC_BIT] = SEC_BIT'(SEC_ASAMA0 + k);
                        if (!asama_rd_hazir_i[k]) begin
                            yukleme_riski = 1'b1;
                        end
                    end
                end
                if (mesgul[indeks_s]) begin
                    mesgul_riski = 1'b1;
                end
            end
        end
    end

    // Destination-side checks: WAW against a busy entry, and issue into
    // the scoreboard only when decode actually advances.
    always_comb begin
        coz_indeks    = INDEKS_BIT'(tablo_indeksi(coz_rd_fp_i, 32'(coz_rd_adres_i), ADRES_BIT));
        coz_rd_gercek = coz_rd_fp_i || (coz_rd_adres_i != '0);
        waw_riski     = coz_gecerli_i && coz_rd_yaz_i && coz_rd_gercek && mesgul[coz_indeks];
        durdur_o      = !dallanma_gerceklesti_i && (yukleme_riski || mesgul_riski || waw_riski);
        ver           = coz_gecerli_i && coz_rd_yaz_i && coz_rd_gercek && !durdur_o &&
                        !dallanma_gerceklesti_i && (coz_gecikme_i != '0);
        yukle         = '0;
        if (ver) begin
            yukle[coz_indeks] = 1'b1;
        end
        getir_atla_o  = dallanma_gerceklesti_i;
    end

`ifdef TEHLIKE_ISTATISTIK_EN
    logic [31:0] durdurma_sayaci_q,    durdurma_sayaci_d;
    logic [31:0] yonlendirme_sayaci_q, yonlendirme_sayaci_d;

    // A forwarding cycle counts only when decode actually advances.
    always_comb begin
        durdurma_sayaci_d    = durdurma_sayaci_q;
        yonlendirme_sayaci_d = yonlendirme_sayaci_q;
        if (durdur_o) begin
            durdurma_sayaci_d = durdurma_sayaci_q + 32'd1;
        end else if (yonlendirme_sec_o != '0) begin
            yonlendirme_sayaci_d = yonlendirme_sayaci_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durdurma_sayaci_q    <= '0;
            yonlendirme_sayaci_q <= '0;
        end else begin
            durdurma_sayaci_q    <= durdurma_sayaci_d;
            yonlendirme_sayaci_q <= yonlendirme_sayaci_d;
        end
    end

    assign durdurma_sayaci_o    = durdurma_sayaci_q;
    assign yonlendirme_sayaci_o = yonlendirme_sayaci_q;
`endif

endmodule

// File: tb/tb_tehlike_puan_tablosu.sv
// ---------------------------------------------------------------------------
// tb_tehlike_puan_tablosu
// Directed bench for tehlike_puan_tablosu: a table of combinational
// forwarding vectors plus hand-written multi-cycle scoreboard sequences.
// Statistics checks are built when TEHLIKE_ISTATISTIK_EN is defined.
// ---------------------------------------------------------------------------
module tb_tehlike_puan_tablosu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [14:0] kaynak_adres_i;
    logic [2:0]  kaynak_fp_i;
    logic [2:0]  kaynak_kullan_i;
    logic [1:0]  asama_rd_yaz_i;
    logic [9:0]  asama_rd_adres_i;
    logic [1:0]  asama_rd_fp_i;
    logic [1:0]  asama_rd_hazir_i;
    logic        coz_gecerli_i;
    logic        coz_rd_yaz_i;
    logic [4:0]  coz_rd_adres_i;
    logic        coz_rd_fp_i;
    logic [3:0]  coz_gecikme_i;
    logic        dallanma_gerceklesti_i;
    logic [5:0]  yonlendirme_sec_o;
    logic        durdur_o;
    logic        getir_atla_o;
`ifdef TEHLIKE_ISTATISTIK_EN
    logic [31:0] durdurma_sayaci_o;
    logic [31:0] yonlendirme_sayaci_o;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       ad;
        logic [14:0] k_adres;
        logic [2:0]  k_fp;
        logic [2:0]  k_kullan;
        logic [1:0]  a_yaz;
        logic [9:0]  a_adres;
        logic [1:0]  a_fp;
        logic [1:0]  a_hazir;
        logic        dallanma;
        logic [5:0]  bek_sec;
        logic        bek_durdur;
    } vektor_t;

    vektor_t vektorler[9];

    tehlike_puan_tablosu dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .kaynak_adres_i         (kaynak_adres_i),
        .kaynak_fp_i            (kaynak_fp_i),
        .kaynak_kullan_i        (kaynak_kullan_i),
        .asama_rd_yaz_i         (asama_rd_yaz_i),
        .asama_rd_adres_i       (asama_rd_adres_i),
        .asama_rd_fp_i          (asama_rd_fp_i),
        .asama_rd_hazir_i       (asama_rd_hazir_i),
        .coz_gecerli_i          (coz_gecerli_i),
        .coz_rd_yaz_i           (coz_rd_yaz_i),
        .coz_rd_adres_i         (coz_rd_adres_i),
        .coz_rd_fp_i            (coz_rd_fp_i),
        .coz_gecikme_i          (coz_gecikme_i),
        .dallanma_gerceklesti_i (dallanma_gerceklesti_i),
        .yonlendirme_sec_o      (yonlendirme_sec_o),
        .durdur_o               (durdur_o),
        .getir_atla_o           (getir_atla_o)
`ifdef TEHLIKE_ISTATISTIK_EN
        ,
        .durdurma_sayaci_o      (durdurma_sayaci_o),
        .yonlendirme_sayaci_o   (yonlendirme_sayaci_o)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the sequence stalls somehow.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string ad, input logic [31:0] gercek,
                               input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", ad, gercek, beklenen);
        end
    endtask

    task automatic idleInputs();
        kaynak_adres_i         = '0;
        kaynak_fp_i            = '0;
        kaynak_kullan_i        = '0;
        asama_rd_yaz_i         = '0;
        asama_rd_adres_i       = '0;
        asama_rd_fp_i          = '0;
        asama_rd_hazir_i       = 2'b11;
        coz_gecerli_i          = 1'b0;
        coz_rd_yaz_i           = 1'b0;
        coz_rd_adres_i         = '0;
        coz_rd_fp_i            = 1'b0;
        coz_gecikme_i          = '0;
        dallanma_gerceklesti_i = 1'b0;
    endtask

    task automatic applyStimulus(input vektor_t v);
        idleInputs();
        kaynak_adres_i         = v.k_adres;
        kaynak_fp_i            = v.k_fp;
        kaynak_kullan_i        = v.k_kullan;
        asama_rd_yaz_i         = v.a_yaz;
        asama_rd_adres_i       = v.a_adres;
        asama_rd_fp_i          = v.a_fp;
        asama_rd_hazir_i       = v.a_hazir;
        dallanma_gerceklesti_i = v.dallanma;
    endtask

    // Decode instruction that only reads source 0.
    task automatic readSrc0(input logic [4:0] adres, input logic fp);
        idleInputs();
        coz_gecerli_i   = 1'b1;
        kaynak_adres_i  = {10'd0, adres};
        kaynak_fp_i     = {2'b00, fp};
        kaynak_kullan_i = 3'b001;
    endtask

    // Decode instruction that only writes rd.
    task automatic writeRd(input logic [4:0] adres, input logic fp, input logic [3:0] gecikme);
        idleInputs();
        coz_gecerli_i  = 1'b1;
        coz_rd_yaz_i   = 1'b1;
        coz_rd_adres_i = adres;
        coz_rd_fp_i    = fp;
        coz_gecikme_i  = gecikme;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vektorler[0] = '{"fwd_oncelik",    {5'd0, 5'd0, 5'd5}, 3'b000, 3'b001, 2'b11, {5'd5, 5'd5}, 2'b00, 2'b11, 1'b0, 6'b000001, 1'b0};
        vektorler[1] = '{"x0_yok",         {5'd0, 5'd0, 5'd0}, 3'b000, 3'b010, 2'b01, {5'd0, 5'd0}, 2'b00, 2'b11, 1'b0, 6'b000000, 1'b0};
        vektorler[2] = '{"f0_asama1",      {5'd0, 5'd0, 5'd0}, 3'b010, 3'b010, 2'b10, {5'd0, 5'd0}, 2'b10, 2'b11, 1'b0, 6'b001000, 1'b0};
        vektorler[3] = '{"yukleme_kullan", {5'd0, 5'd0, 5'd7}, 3'b000, 3'b001, 2'b01, {5'd0, 5'd7}, 2'b00, 2'b10, 1'b0, 6'b000001, 1'b1};
        vektorler[4] = '{"yukleme_hazir",  {5'd0, 5'd0, 5'd7}, 3'b000, 3'b001, 2'b01, {5'd0, 5'd7}, 2'b00, 2'b11, 1'b0, 6'b000001, 1'b0};
        vektorler[5] = '{"fp_ayrim",       {5'd0, 5'd0, 5'd5}, 3'b001, 3'b001, 2'b11, {5'd5, 5'd5}, 2'b10, 2'b01, 1'b0, 6'b000010, 1'b1};
        vektorler[6] = '{"kullanilmayan",  {5'd9, 5'd0, 5'd0}, 3'b000, 3'b000, 2'b01, {5'd0, 5'd9}, 2'b00, 2'b11, 1'b0, 6'b000000, 1'b0};
        vektorler[7] = '{"dallanma_bastir",{5'd0, 5'd0, 5'd7}, 3'b000, 3'b001, 2'b01, {5'd0, 5'd7}, 2'b00, 2'b10, 1'b1, 6'b000001, 1'b0};
        vektorler[8] = '{"coklu_kaynak",   {5'd9, 5'd0, 5'd3}, 3'b000, 3'b101, 2'b11, {5'd9, 5'd3}, 2'b00, 2'b11, 1'b0, 6'b100001, 1'b0};

        // Reset and reset-state checks.
        idleInputs();
        rst_i = 1'b1;
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
        readSrc0(5'd3, 1'b1);
        @(negedge clk);
        checkOutput("reset_durdur", 32'(durdur_o), 32'd0);
        checkOutput("reset_sec", 32'(yonlendirme_sec_o), 32'd0);
        checkOutput("reset_getir_atla", 32'(getir_atla_o), 32'd0);
        nextCycle();

        // Table-driven forwarding vectors (decode idle, so nothing issues).
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vektorler[i]);
            @(negedge clk);
            checkOutput({vektorler[i].ad, "_sec"}, 32'(yonlendirme_sec_o), 32'(vektorler[i].bek_sec));
            checkOutput({vektorler[i].ad, "_durdur"}, 32'(durdur_o), 32'(vektorler[i].bek_durdur));
            checkOutput({vektorler[i].ad, "_getir_atla"}, 32'(getir_atla_o), 32'(vektorler[i].dallanma));
            nextCycle();
        end

        // fdiv f3, latency 4: readers stall cycles 1..4, free on cycle 5.
        writeRd(5'd3, 1'b1, 4'd4);
        @(negedge clk);
        checkOutput("fdiv_ver_durdur", 32'(durdur_o), 32'd0);
        nextCycle();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) writeRd(5'd3, 1'b1, 4'd0);
            else        readSrc0(5'd3, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("fdiv_dongu%0d_durdur", c), 32'(durdur_o), (c <= 4) ? 32'd1 : 32'd0);
            nextCycle();
        end

        // Latency-1 issue: exactly one stalled reader cycle.
        writeRd(5'd10, 1'b0, 4'd1);
        nextCycle();
        readSrc0(5'd10, 1'b0);
        @(negedge clk);
        checkOutput("gecikme1_durdur", 32'(durdur_o), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("gecikme1_serbest", 32'(durdur_o), 32'd0);
        nextCycle();

        // Branch suppresses issue of a latency-3 instruction.
        writeRd(5'd4, 1'b0, 4'd3);
        dallanma_gerceklesti_i = 1'b1;
        @(negedge clk);
        checkOutput("dallanma_getir_atla", 32'(getir_atla_o), 32'd1);
        checkOutput("dallanma_durdur", 32'(durdur_o), 32'd0);
        nextCycle();
        readSrc0(5'd4, 1'b0);
        @(negedge clk);
        checkOutput("dallanma_girdi_yok", 32'(durdur_o), 32'd0);
        nextCycle();

        // A stalled decode must not issue its destination.
        writeRd(5'd1, 1'b1, 4'd3);
        kaynak_adres_i   = {10'd0, 5'd7};
        kaynak_kullan_i  = 3'b001;
        asama_rd_yaz_i   = 2'b01;
        asama_rd_adres_i = {5'd0, 5'd7};
        asama_rd_hazir_i = 2'b10;
        @(negedge clk);
        checkOutput("durmus_ver_durdur", 32'(durdur_o), 32'd1);
        nextCycle();
        readSrc0(5'd1, 1'b1);
        @(negedge clk);
        checkOutput("durmus_ver_girdi_yok", 32'(durdur_o), 32'd0);
        nextCycle();

        // Integer x0 never becomes busy.
        writeRd(5'd0, 1'b0, 4'd5);
        nextCycle();
        readSrc0(5'd0, 1'b0);
        @(negedge clk);
        checkOutput("x0_okuma", 32'(durdur_o), 32'd0);
        nextCycle();
        writeRd(5'd0, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("x0_waw", 32'(durdur_o), 32'd0);
        nextCycle();

        // Reset during a pending fdiv clears the entry.
        writeRd(5'd6, 1'b1, 4'd5);
        nextCycle();
        readSrc0(5'd6, 1'b1);
        @(negedge clk);
        checkOutput("reset_oncesi_durdur", 32'(durdur_o), 32'd1);
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("reset_sonrasi_durdur", 32'(durdur_o), 32'd0);
        nextCycle();

`ifdef TEHLIKE_ISTATISTIK_EN
        // Three load-use stall cycles then two forwarding cycles.
        idleInputs();
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            readSrc0(5'd7, 1'b0);
            asama_rd_yaz_i   = 2'b01;
            asama_rd_adres_i = {5'd0, 5'd7};
            asama_rd_hazir_i = (c < 3) ? 2'b10 : 2'b11;
            nextCycle();
        end
        idleInputs();
        @(negedge clk);
        checkOutput("istatistik_durdurma", durdurma_sayaci_o, 32'd3);
        checkOutput("istatistik_yonlendirme", yonlendirme_sayaci_o, 32'd2);
        nextCycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tehlike_puan_tablosu.md
Name: tehlike_puan_tablosu

Overview:
- Parametrised successor to the core hazard/forwarding unit.
- Generates forwarding selects for N source operands across K forwarding stages (integer and FP register files).
- Adds a sequential scoreboard for multi-cycle units (divider, FPU) that drives decode stall and WAW protection.
- Sits beside the decode (coz) stage and is fed by the yurut and geri_yaz pipeline stages.

Parameters:
- KAYNAK_SAYISI, 3, number of source operands checked per instruction (rs1..rsN).
- ASAMA_SAYISI, 2, forwarding stages; index 0 is nearest (yurut), 1 is geri_yaz, and so on.
- ADRES_BIT, 5, register address width.
- GECIKME_BIT, 4, scoreboard countdown width; maximum latency is 2^GECIKME_BIT-1.
- SEC_BIT, $clog2(ASAMA_SAYISI+1), forwarding-select width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- kaynak_adres_i  in  KAYNAK_SAYISI*ADRES_BIT  source addresses, packed, source 0 in LSBs.
- kaynak_fp_i  in  KAYNAK_SAYISI  per-source: 1 = FP register file.
- kaynak_kullan_i  in  KAYNAK_SAYISI  per-source: the source is actually read.
- asama_rd_yaz_i  in  ASAMA_SAYISI  stage k writes rd.
- asama_rd_adres_i  in  ASAMA_SAYISI*ADRES_BIT  stage k rd address.
- asama_rd_fp_i  in  ASAMA_SAYISI  stage k rd is FP.
- asama_rd_hazir_i  in  ASAMA_SAYISI  stage k result value is valid.
- coz_gecerli_i  in  1  decode holds a valid instruction.
- coz_rd_yaz_i  in  1  decoded instruction writes rd.
- coz_rd_adres_i  in  ADRES_BIT  decoded rd.
- coz_rd_fp_i  in  1  decoded rd is FP.
- coz_gecikme_i  in  GECIKME_BIT  cycles until the multi-cycle result reaches stage 0; 0 = single-cycle op.
- dallanma_gerceklesti_i  in  1  branch taken / flush.
- yonlendirme_sec_o  out  KAYNAK_SAYISI*SEC_BIT  per source: 0 = register file, k+1 = forward from stage k.
- durdur_o  out  1  stall fetch/decode.
- getir_atla_o  out  1  flush fetch.

Behaviour:
- Scoreboard: 64 entries, index {fp, adres}. Each entry holds a mesgul bit and a GECIKME_BIT sayac.
- Reset (rst_i=1 at a clock edge): all mesgul bits and counters are cleared. Consequence: durdur_o=0, yonlendirme_sec_o=0 and getir_atla_o equals dallanma_gerceklesti_i, given inputs that do not themselves cause a stall. Reset asserted mid-operation discards all pending entries in that cycle.
- Issue: ver = coz_gecerli_i & coz_rd_yaz_i & !durdur_o & !dallanma_gerceklesti_i & (coz_gecikme_i != 0).
  - An integer rd of 0 never issues.
  - On ver, the entry gets mesgul=1 and sayac=coz_gecikme_i at the next edge.
- Countdown: each cycle, every entry with mesgul=1 decrements sayac. On the 1->0 transition, mesgul clears at the same edge, and the result is visible on stage-0 inputs from the next cycle.
- Issue and countdown-completion to the same index on the same edge: issue wins (entry reloaded). This cannot happen legally because of WAW stall, but RTL must resolve it this way.
- Forwarding, per source s with kaynak_kullan_i[s]=1:
  - Scan stages 0..K-1; the first k with asama_rd_yaz_i[k], matching address and matching fp flag wins.
  - Integer address 0 never matches. FP address 0 does match.
  - Select = k+1, or 0 if no stage matches.
  - If kaynak_kullan_i[s]=0, select = 0.
- durdur_o (combinational) is the OR of:
  - (a) any used source whose winning stage has asama_rd_hazir_i[k]=0 (load-use hazard); the select is still driven.
  - (b) any used source whose scoreboard entry has mesgul=1 (integer index 0 excluded).
  - (c) coz_gecerli_i & coz_rd_yaz_i with a busy destination entry (WAW hazard).
- durdur_o is forced to 0 while dallanma_gerceklesti_i=1.
- getir_atla_o = dallanma_gerceklesti_i, combinational, zero latency.
- No output is registered except the statistics counters (Optional Feature).

Optional Feature:
- Macro: TEHLIKE_ISTATISTIK_EN.
- When defined:
  - Extra outputs durdurma_sayaci_o[31:0] and yonlendirme_sayaci_o[31:0], reset to 0.
  - durdurma_sayaci_o increments on every cycle with durdur_o=1.
  - yonlendirme_sayaci_o increments by 1 on any cycle where at least one select is non-zero and durdur_o=0.
  - Both counters wrap modulo 2^32.
- When not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package tehlike_paket:
  - ADRES_BIT default.
  - Select encoding constants: SEC_RF=0, SEC_ASAMA0=1.
  - Scoreboard index helper function {fp, adres}.
- Sub-module puan_tablosu_girdisi: one entry (mesgul + sayac + issue/countdown logic), instantiated in a generate loop 64 times.
- Forwarding priority scan is an in-module loop.

Test Plan:
- Source0 = x5 int; stage0 writes x5 hazir=1; stage1 also writes x5 -> select0 = 1, durdur_o = 0.
- Source1 = x0 int; stage0 writes x0 -> select1 = 0. Source1 = f0 FP; stage1 writes f0 FP -> select1 = 2.
- Stage0 writes x7 with hazir=0; source0 = x7 -> durdur_o = 1; hazir=1 the next cycle -> durdur_o = 0, select0 = 1.
- Issue fdiv f3 with gecikme=4 -> reading f3 stalls exactly 4 cycles; cycle 5 durdur_o = 0. A WAW write to f3 in cycles 1-4 also stalls.
- dallanma_gerceklesti_i=1 with a gecikme=3 issue pending -> getir_atla_o = 1, no entry set, durdur_o = 0. rst_i during a pending fdiv -> entry cleared next cycle.
- TEHLIKE_ISTATISTIK_EN defined: 3 stall cycles plus 2 forward cycles -> counters read 3 and 2; preset to 0xFFFFFFFF -> wraps to 0.
